spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
Sequences the byte-level SPI master for multi-byte bursts so the CPU does not hand-shake every byte through the 65006–65009 IO registers. The block has three parts:
- TX FIFO, filled by the CPU.
- RX FIFO, drained by the CPU.
- Burst FSM that drives chip select, pulses the master's start, and captures each received byte.
It sits between the CPU IO decode and the `spi` instance, clocked from the same 50 MHz domain as the master.

Parameters:
- DEPTH, 16: entries in each of the TX and RX FIFOs (power of 2).
- PTR_W, 4: log2(DEPTH).
- CS_SETUP, 4: clk cycles from select asserted to the first start pulse; also the hold time after the last byte.
- GAP, 2: idle clk cycles between consecutive bytes.

Ports:
- clk, in, 1: system clock (50 MHz).
- reset, in, 1: asynchronous, active-high reset.
- tx_wr, in, 1: push tx_data into the TX FIFO.
- tx_data, in, 8: byte to transmit.
- rx_rd, in, 1: pop the RX FIFO head.
- rx_data, out, 8: RX FIFO head (show-ahead).
- go, in, 1: start a burst (sampled only in IDLE).
- len, in, PTR_W+1: number of bytes in the burst, 1..DEPTH.
- dev_sel, in, 2: bit0 selects USB, bit1 selects SD card; latched on go.
- abort, in, 1: terminate the burst.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse at burst end.
- tx_full, out, 1: TX FIFO full.
- tx_empty, out, 1: TX FIFO empty.
- rx_empty, out, 1: RX FIFO empty.
- rx_ovf, out, 1: sticky RX overflow flag.
- ss_usb, out, 1: USB select, active-high (inverted at the top level).
- ss_sd, out, 1: SD card select, active-high.
- spi_start, out, 1: start pulse to the master.
- spi_din, out, 8: byte presented to the master.
- spi_dout, in, 8: byte received from the master.
- spi_busy, in, 1: master busy.
- spi_new_data, in, 1: master received-byte strobe.

Behaviour:
Reset (asynchronous):
- State IDLE; both FIFOs empty.
- All outputs 0, except tx_empty = 1 and rx_empty = 1.
- rx_data = 0x00.

FIFOs:
- Circular buffers with PTR_W-bit pointers and a (PTR_W+1)-bit count.
- tx_wr when tx_full is dropped.
- rx_rd when rx_empty is ignored.
- A simultaneous push and pop leaves the count unchanged.
- Flags are updated on the clock edge after the change.

FSM states:
- IDLE
  - go=1 with 1 ≤ len ≤ DEPTH: latch len into the byte counter, latch dev_sel, clear rx_ovf, go to SETUP.
  - go=1 with len=0 or len > DEPTH: ignored, no done pulse.
- SETUP
  - Selected ss_* lines high from the first SETUP cycle.
  - Wait CS_SETUP cycles, then go to START.
- START
  - Wait while spi_busy=1.
  - When spi_busy=0, drive spi_start=1 for exactly one cycle with spi_din = TX head, popping the TX FIFO in the same cycle.
  - If the TX FIFO is empty, send 0xFF and pop nothing.
  - Go to WAIT.
- WAIT
  - On spi_new_data=1: push spi_dout into the RX FIFO. If the RX FIFO is full, drop the byte and set rx_ovf.
  - Decrement the counter.
  - Counter reaches 0: go to HOLD. Otherwise go to GAP.
- GAP
  - Wait GAP cycles, then go to START.
- HOLD
  - Wait CS_SETUP cycles, then deassert ss_*.
  - Pulse done for one cycle and go to IDLE.

Abort:
- abort=1 in any state other than IDLE: next cycle ss_* = 0, spi_start = 0, state IDLE, done = 1 for one cycle.
- FIFO contents are kept.
- spi_new_data outside WAIT is ignored.

Other rules:
- go while busy is ignored.
- A CPU tx_wr during a burst is legal; the byte is sent if it is queued before its START.
- Counter arithmetic is unsigned PTR_W+1 bits; the counter never wraps because len=0 is rejected.
- A reset mid-burst drops select immediately (asynchronously).

Optional Feature:
SPI_BURST_KEEP_CS_EN
- Defined: adds input `keep_cs`, latched on go.
  - If keep_cs=1, HOLD pulses done and returns to IDLE with the selected ss_* still high.
  - A following go with the same dev_sel skips SETUP and goes directly to START.
  - A go with a different dev_sel, a go with keep_cs=0 at the end of its burst, or an abort deasserts select.
- Undefined: no port; select always drops in HOLD.

Test Plan:
1. Push 0x40,0x00,0x00,0x00,0x00,0x95; go with len=6, dev_sel=2'b10; master model echoes the byte XOR 0xFF.
   -> ss_sd high for the whole burst, 6 start pulses, RX holds 0xBF,0xFF,0xFF,0xFF,0xFF,0x6A, done once, ss_sd low CS_SETUP cycles after the 6th new_data.
2. TX FIFO empty; go with len=3.
   -> spi_din = 0xFF on all 3 starts; tx_empty stays 1.
3. RX holds 15 bytes; burst with len=3.
   -> 1 byte stored, rx_ovf=1; next go clears rx_ovf.
4. abort in WAIT of byte 2 of a 4-byte burst.
   -> next cycle ss_* = 0 and busy = 0, done pulse, a late new_data is not stored.
5. go with len=0, and go while busy.
   -> no state change, no done pulse.
6. Assert reset mid-START.
   -> ss_* and spi_start go to 0 asynchronously; FIFOs empty; a 1-byte burst after reset completes normally.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: burst sequencer in front of the byte-level SPI master.
// Holds a TX FIFO (CPU fills) and an RX FIFO (CPU drains). A burst FSM
// drives chip select, pulses the master's start and captures each byte.
// Optional build macro SPI_BURST_KEEP_CS_EN adds a keep_cs input so
// select can stay asserted across back-to-back bursts to the same device.

module spi_burst_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Show-ahead head; reads as zero when there is nothing queued.
  assign rdata_o = empty_o ? 8'h00 : mem_q[rp_q];

  // Pointer and occupancy tracking; push+pop together keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

module spi_burst_ctrl #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int CS_SETUP = 4,
  parameter int GAP      = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_wr,
  input  logic [7:0]     tx_data,
  input  logic           rx_rd,
  output logic [7:0]     rx_data,
  input  logic           go,
  input  logic [PTR_W:0] len,
  input  logic [1:0]     dev_sel,
  input  logic           abort,
`ifdef SPI_BURST_KEEP_CS_EN
  input  logic           keep_cs,
`endif
  output logic           busy,
  output logic           done,
  output logic           tx_full,
  output logic           tx_empty,
  output logic           rx_empty,
  output logic           rx_ovf,
  output logic           ss_usb,
  output logic           ss_sd,
  output logic           spi_start,
  output logic [7:0]     spi_din,
  input  logic [7:0]     spi_dout,
  input  logic           spi_busy,
  input  logic           spi_new_data
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_GAP, S_HOLD} state_t;

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     SETUP_T = 8'(CS_SETUP - 1);
  localparam logic [7:0]     GAP_T   = 8'(GAP - 1);

  state_t         st_q;
  logic [PTR_W:0] cnt_q;
  logic [7:0]     tmr_q;
  logic [1:0]     ss_q;
  logic           start_q, done_q, busy_q, ovf_q;
  logic [7:0]     din_q;
`ifdef SPI_BURST_KEEP_CS_EN
  logic           keep_q, held_q;
`endif

  logic       len_ok, tx_pop, rx_push, rx_full;
  logic [7:0] tx_head;

  assign len_ok  = (len != '0) && (len <= DEPTH_L);
  // Pop the TX head in the same cycle the start pulse is scheduled.
  assign tx_pop  = (st_q == S_START) && !spi_busy && !abort;
  // Received bytes only count while waiting on the master; abort wins.
  assign rx_push = (st_q == S_WAIT) && spi_new_data && !abort;

  spi_burst_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx (
    .clk(clk), .reset(reset), .push_i(tx_wr), .pop_i(tx_pop),
    .wdata_i(tx_data), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  spi_burst_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx (
    .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_rd),
    .wdata_i(spi_dout), .rdata_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_ovf    = ovf_q;
  assign ss_usb    = ss_q[0];
  assign ss_sd     = ss_q[1];
  assign spi_start = start_q;
  assign spi_din   = din_q;

  // Burst sequencer with registered select/start/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      ss_q    <= '0;
      start_q <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SPI_BURST_KEEP_CS_EN
      keep_q  <= 1'b0;
      held_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (rx_push && rx_full) ovf_q <= 1'b1;

      if (abort && st_q != S_IDLE) begin
        st_q   <= S_IDLE;
        ss_q   <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
`ifdef SPI_BURST_KEEP_CS_EN
        held_q <= 1'b0;
`endif
      end else begin
        case (st_q)
          S_IDLE: begin
            if (go && len_ok) begin
              cnt_q  <= len;
              ovf_q  <= 1'b0;
              busy_q <= 1'b1;
              ss_q   <= dev_sel;
              tmr_q  <= SETUP_T;
              st_q   <= S_SETUP;
`ifdef SPI_BURST_KEEP_CS_EN
              keep_q <= keep_cs;
              held_q <= 1'b0;
              // Select already settled on this device: no setup wait.
              if (held_q && dev_sel == ss_q) st_q <= S_START;
            end else if (abort && held_q) begin
              ss_q   <= '0;
              held_q <= 1'b0;
`endif
            end
          end
          S_SETUP: begin
            if (tmr_q == '0) st_q <= S_START;
            else             tmr_q <= tmr_q - 8'd1;
          end
          S_START: begin
            if (!spi_busy) begin
              start_q <= 1'b1;
              din_q   <= tx_empty ? 8'hFF : tx_head;
              st_q    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (spi_new_data) begin
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == (PTR_W+1)'(1)) begin
                st_q  <= S_HOLD;
                tmr_q <= SETUP_T;
              end else if (GAP == 0) begin
                st_q  <= S_START;
              end else begin
                st_q  <= S_GAP;
                tmr_q <= GAP_T;
              end
            end
          end
          S_GAP: begin
            if (tmr_q == '0) st_q <= S_START;
            else             tmr_q <= tmr_q - 8'd1;
          end
          S_HOLD: begin
            if (tmr_q == '0) begin
              st_q   <= S_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
`ifdef SPI_BURST_KEEP_CS_EN
              if (keep_q) held_q <= 1'b1;
              else        ss_q   <= '0;
`else
              ss_q   <= '0;
`endif
            end else begin
              tmr_q <= tmr_q - 8'd1;
            end
          end
          default: st_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a simple SPI master echo model.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 16, PTR_W = 4, CS_SETUP = 4, GAP = 2;

  logic clk = 0, reset = 0, tx_wr = 0, rx_rd = 0, go = 0, abort = 0;
  logic [7:0]     tx_data = 0;
  logic [PTR_W:0] len = 0;
  logic [1:0]     dev_sel = 0;
  logic [7:0]     rx_data, spi_din, spi_dout;
  logic busy, done, tx_full, tx_empty, rx_empty, rx_ovf, ss_usb, ss_sd;
  logic spi_start, spi_busy, spi_new_data;
  logic force_busy = 0;
  int checks = 0, errors = 0;

  always #10 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CS_SETUP(CS_SETUP), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .rx_rd(rx_rd),
    .rx_data(rx_data), .go(go), .len(len), .dev_sel(dev_sel), .abort(abort),
    .busy(busy), .done(done), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_empty(rx_empty), .rx_ovf(rx_ovf), .ss_usb(ss_usb), .ss_sd(ss_sd),
    .spi_start(spi_start), .spi_din(spi_din), .spi_dout(spi_dout),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data)
  );

  // Master model: busy for a few cycles after start, then echoes ~din.
  logic       m_busy = 0, m_nd = 0;
  logic [7:0] m_dout = 0, m_byte = 0;
  int         m_cnt = 0;
  always @(posedge clk) begin
    m_nd <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_nd   <= 1'b1;
        m_dout <= m_byte ^ 8'hFF;
        m_busy <= 1'b0;
      end
    end else if (spi_start) begin
      m_busy <= 1'b1;
      m_byte <= spi_din;
      m_cnt  <= 3;
    end
  end
  assign spi_busy     = m_busy | force_busy;
  assign spi_new_data = m_nd;
  assign spi_dout     = m_dout;

  // Event monitor sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int starts = 0, dones = 0, non_ff = 0, sd_low_busy = 0, usb_hi = 0;
  int last_nd = 0, sd_fall = 0;
  logic prev_sd = 0;
  logic [7:0] din_log [64];
  always @(negedge clk) begin
    if (spi_start) begin
      if (starts < 64) din_log[starts] <= spi_din;
      starts <= starts + 1;
      if (spi_din != 8'hFF) non_ff <= non_ff + 1;
    end
    if (done) dones <= dones + 1;
    if (busy && !ss_sd) sd_low_busy <= sd_low_busy + 1;
    if (ss_usb) usb_hi <= usb_hi + 1;
    if (spi_new_data) last_nd <= cyc;
    if (prev_sd && !ss_sd) sd_fall <= cyc;
    prev_sd <= ss_sd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); tx_wr = 1; tx_data = b;
    @(negedge clk); tx_wr = 0;
  endtask

  task automatic start_burst(input logic [PTR_W:0] l, input logic [1:0] d);
    @(negedge clk); go = 1; len = l; dev_sel = d;
    @(negedge clk); go = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(tag, done, 1);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, rx_data, exp);
    rx_rd = 1;
    @(negedge clk); rx_rd = 0;
  endtask

  logic [7:0] t1_tx [6] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};

  initial begin
    int s0, d0, b0, u0, n0, n;
    logic [7:0] v;

    // Reset state
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_outs", {busy, done, ss_usb, ss_sd, spi_start, rx_ovf, tx_full}, 0);
    chk("rst_flags", {tx_empty, rx_empty}, 2'b11);
    chk("rst_data", {spi_din, rx_data}, 0);

    // 1: six-byte SD burst with echo
    for (int i = 0; i < 6; i++) push(t1_tx[i]);
    s0 = starts; d0 = dones; b0 = sd_low_busy; u0 = usb_hi;
    start_burst(6, 2'b10);
    chk("t1_busy_sel", {busy, ss_sd}, 2'b11);
    wait_done("t1_done");
    repeat (3) @(negedge clk);
    chk("t1_starts", starts - s0, 6);
    for (int i = 0; i < 6; i++) chk("t1_din", din_log[s0+i], t1_tx[i]);
    chk("t1_done_cnt", dones - d0, 1);
    chk("t1_sd_held", sd_low_busy - b0, 0);
    chk("t1_usb_quiet", usb_hi - u0, 0);
    chk("t1_hold_time", sd_fall - last_nd, CS_SETUP + 1);
    chk("t1_idle", {busy, ss_sd}, 0);
    pop_chk("t1_rx0", 8'hBF);
    for (int i = 1; i < 5; i++) pop_chk("t1_rx", 8'hFF);
    pop_chk("t1_rx5", 8'h6A);
    chk("t1_rx_empty", rx_empty, 1);

    // 2: empty TX sends 0xFF
    s0 = starts; n0 = non_ff;
    start_burst(3, 2'b01);
    wait_done("t2_done");
    repeat (3) @(negedge clk);
    chk("t2_starts", starts - s0, 3);
    chk("t2_all_ff", non_ff - n0, 0);
    chk("t2_tx_empty", tx_empty, 1);
    for (int i = 0; i < 3; i++) pop_chk("t2_rx", 8'h00);
    chk("t2_rx_empty", rx_empty, 1);

    // 3: TX full boundary, RX overflow, overflow cleared by next go
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t3_tx_full", tx_full, 1);
    push(8'hEE);
    chk("t3_tx_full2", tx_full, 1);
    start_burst(15, 2'b10);
    wait_done("t3_done15");
    chk("t3_no_ovf", rx_ovf, 0);
    start_burst(3, 2'b10);
    wait_done("t3_done3");
    chk("t3_ovf", rx_ovf, 1);
    chk("t3_tx_empty", tx_empty, 1);
    for (int i = 0; i < 16; i++) begin
      v = (i < 15) ? ~8'(i) : 8'hF0;
      pop_chk("t3_rx", v);
    end
    chk("t3_rx_empty", rx_empty, 1);
    start_burst(1, 2'b10);
    chk("t3_ovf_clr", rx_ovf, 0);
    wait_done("t3_done1");
    pop_chk("t3_rx_last", 8'h00);

    // 4: abort during WAIT of byte 2
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    d0 = dones;
    start_burst(4, 2'b10);
    n = 0;
    for (int k = 0; k < 500 && n < 2; k++) begin
      @(negedge clk);
      if (spi_start) n++;
    end
    chk("t4_second_start", n, 2);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("t4_abort_outs", {ss_sd, ss_usb, busy, done}, 4'b0001);
    repeat (12) @(negedge clk);
    chk("t4_done_cnt", dones - d0, 1);
    chk("t4_tx_kept", tx_empty, 0);
    pop_chk("t4_rx0", 8'hEE);
    chk("t4_late_dropped", rx_empty, 1);

    // 5: rejected go (len 0, len > DEPTH, go while busy)
    d0 = dones; s0 = starts;
    start_burst(0, 2'b10);
    chk("t5_len0", {busy, ss_sd}, 0);
    start_burst(5'd17, 2'b10);
    chk("t5_len17", {busy, ss_sd}, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_done", dones - d0, 0);
    start_burst(2, 2'b10);
    repeat (3) @(negedge clk);
    start_burst(5, 2'b01);
    chk("t5_busy_go_sel", {ss_usb, ss_sd}, 2'b01);
    wait_done("t5_done");
    repeat (3) @(negedge clk);
    chk("t5_done_cnt", dones - d0, 1);
    chk("t5_starts", starts - s0, 2);
    pop_chk("t5_rx0", 8'hCC);
    pop_chk("t5_rx1", 8'hBB);
    chk("t5_tx_empty", tx_empty, 1);

    // 6: asynchronous reset while stalled in START
    push(8'h77);
    force_busy = 1;
    start_burst(2, 2'b11);
    repeat (10) @(negedge clk);
    chk("t6_stalled", {ss_usb, ss_sd, busy, spi_start}, 4'b1110);
    #5 reset = 1;
    #1;
    chk("t6_async", {ss_usb, ss_sd, spi_start, busy}, 0);
    chk("t6_fifos", {tx_empty, rx_empty}, 2'b11);
    @(negedge clk);
    reset = 0; force_busy = 0;
    push(8'h5A);
    s0 = starts;
    start_burst(1, 2'b01);
    wait_done("t6_done");
    repeat (2) @(negedge clk);
    chk("t6_starts", starts - s0, 1);
    chk("t6_din", din_log[s0], 8'h5A);
    chk("t6_rx", rx_data, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
